hps_reset_pulse_sequencer: RTL and testbench
============================================

# hps_reset_pulse_sequencer

Parametrised, multi-channel successor to the single-channel reset-request edge/pulse chain in the GHRD top. It sits between the source/probe reset-request bits and the HPS `f2h_*_reset_req` inputs. Each channel edge-detects an asynchronous request and queues it. A fixed-priority sequencer then emits exactly one stretched pulse at a time, with a per-channel pulse length and a global cooldown, so cold, warm and debug requests can never overlap.

## Interface
- `NUM_CH`, 3 — number of request channels; channel 0 has the highest priority.
- `CNT_W`, 8 — width of the pulse and holdoff counters.
- `PULSE_EXT_VEC`, {8'd32, 8'd2, 8'd6} — packed `NUM_CH*CNT_W` bits; slice `[i*CNT_W +: CNT_W]` is the pulse length of channel i in cycles; 0 is treated as 1.
- `EDGE_TYPE`, 1 — 1 detects rising edges, 0 detects falling edges (all channels).
- `HOLDOFF`, 16 — idle cycles enforced after each pulse (< 2^CNT_W).

Ports:
- `clk` in 1 — single clock.
- `rst` in 1 — reset, synchronous and active-high.
- `req_in` in NUM_CH — asynchronous request levels.
- `clr_overflow` in 1 — clears all `overflow` bits.
- `pulse_out` in/out: out NUM_CH — active-high stretched pulses; one-hot or zero.
- `pending` out NUM_CH — queued, not yet granted requests.
- `overflow` out NUM_CH — sticky; a request merged into one already pending.
- `busy` out 1 — high in PULSE or HOLDOFF.

## Operation
- Each channel has a 2-FF synchronizer (`s1`, `s2`) and a `prev` register.
- Edge condition: `s2 & ~prev` when EDGE_TYPE=1, `~s2 & prev` when EDGE_TYPE=0.
- Arming: edge detection is masked for 3 cycles after `rst` deasserts. This lets `s1`/`s2`/`prev` fill and prevents a spurious edge from a static input level.
- A detected edge sets `pending[i]`. If `pending[i]` is already 1, `overflow[i]` is set instead; the requests merge.
- FSM states:
  - IDLE → PULSE when `pending != 0`. Grant the lowest set index g, clear `pending[g]`, load `cnt = max(PULSE_EXT[g],1)`, set `pulse_out = 1<<g`.
  - PULSE: decrement `cnt` each cycle. When `cnt == 1`, clear `pulse_out` and go to HOLDOFF with `cnt = HOLDOFF`. If HOLDOFF=0, go straight to IDLE.
  - HOLDOFF: decrement; at `cnt == 1` go to IDLE.
- An edge on the currently granted channel during PULSE or HOLDOFF sets its `pending` bit, so it is re-served after the cooldown.
- Simultaneous edges on several channels set all of their bits; they are served in index order.
- `clr_overflow` and a new overflow in the same cycle: the set wins.

Reset values: `pulse_out` = 0, `pending` = 0, `overflow` = 0, `busy` = 0, FSM = IDLE, `cnt` = 0.
- Synchronizer/`prev` reset value: 0 when EDGE_TYPE=1, all-ones when EDGE_TYPE=0.

## Timing
- Latency: input transition sampled by `s1` at edge n.
  - `pending` is set at n+2.
  - `pulse_out` rises at n+3.
- `pulse_out[g]` stays high for exactly `max(PULSE_EXT[g],1)` cycles.
- Gap between the fall of one pulse and the rise of the next: `HOLDOFF+1` cycles. That is one IDLE cycle; HOLDOFF=0 gives a gap of 1.
- `busy` is registered and aligns with the FSM state: high from the first PULSE cycle to the last HOLDOFF cycle.
- Edges are detected once per transition; a held level never re-triggers.

## Configuration
- `HPS_RSTSEQ_IGNORE_RST_WHILE_BUSY_EN` defined:
  - While FSM=PULSE, `rst` is masked for the FSM, `cnt` and `pulse_out`, so the active pulse runs to full length.
  - Synchronizers, `pending`, `overflow` and the arming counter still reset immediately.
  - The first cycle after PULSE ends with `rst` high applies the full reset (FSM → IDLE, skipping HOLDOFF).
- Not defined: `rst` clears everything; `pulse_out` drops at the next edge.

## Test plan
- Reset release with `req_in[0]` held high, EDGE_TYPE=1 → no pulse for 50 cycles; `pending` = 0.
- Rising edge on ch1 only, defaults → `pulse_out` = 3'b010 from n+3 for 2 cycles; `busy` high for 2+16 cycles; `pending` cleared at grant.
- Edges on ch0 and ch2 in the same cycle → ch0 pulse (6 cycles), then after 17 idle cycles a ch2 pulse (32 cycles); `pulse_out` is never multi-hot.
- Two ch2 edges before grant → a single ch2 pulse; `overflow[2]` = 1 until `clr_overflow`, then 0.
- `rst` high for 1 cycle during cycle 10 of a ch2 pulse:
  - Without the macro: `pulse_out` is 0 at the next edge.
  - With the macro: the pulse completes all 32 cycles, then FSM = IDLE and `busy` = 0.
- EDGE_TYPE=0, PULSE_EXT of ch0 = 0, falling edge on ch0 → 1-cycle pulse on `pulse_out[0]`.

Source files
------------

// File: rtl/hps_reset_pulse_sequencer.sv
// Multi-channel reset-request sequencer: edge-detect, queue, then emit one stretched pulse at a time.
// Optional HPS_RSTSEQ_IGNORE_RST_WHILE_BUSY_EN lets an active pulse finish through a reset.
module hps_reset_pulse_sequencer #(
  parameter int                       NUM_CH        = 3,
  parameter int                       CNT_W         = 8,
  parameter logic [NUM_CH*CNT_W-1:0]  PULSE_EXT_VEC = {8'd32, 8'd2, 8'd6},
  parameter bit                       EDGE_TYPE     = 1'b1,
  parameter int                       HOLDOFF       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req_in,
  input  logic              clr_overflow,
  output logic [NUM_CH-1:0] pulse_out,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] overflow,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;

  localparam logic [NUM_CH-1:0] SYNC_INIT = EDGE_TYPE ? {NUM_CH{1'b0}} : {NUM_CH{1'b1}};

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [NUM_CH-1:0] s1, s2, prev;
  logic [1:0]        arm_cnt;
  logic              armed;
  logic [NUM_CH-1:0] edge_det;
  logic [NUM_CH-1:0] grant_sel;
  logic              fsm_rst;

  function automatic logic [NUM_CH-1:0] lowest_set(input logic [NUM_CH-1:0] v);
    logic [NUM_CH-1:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  // A programmed length of 0 still yields a one-cycle pulse.
  function automatic logic [CNT_W-1:0] pulse_len(input logic [NUM_CH-1:0] sel);
    logic [CNT_W-1:0] len;
    len = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel[i]) len = PULSE_EXT_VEC[i*CNT_W +: CNT_W];
    end
    return (len == '0) ? CNT_W'(1) : len;
  endfunction

`ifdef HPS_RSTSEQ_IGNORE_RST_WHILE_BUSY_EN
  logic rst_defer;

  // Remember a reset seen mid-pulse and apply it once the pulse has ended.
  always_ff @(posedge clk) begin
    if (state == PULSE) rst_defer <= rst_defer | rst;
    else                rst_defer <= 1'b0;
  end

  assign fsm_rst = (rst | rst_defer) & (state != PULSE);
`else
  assign fsm_rst = rst;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= SYNC_INIT;
      s2   <= SYNC_INIT;
      prev <= SYNC_INIT;
    end else begin
      s1   <= req_in;
      s2   <= s1;
      prev <= s2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         arm_cnt <= 2'd0;
    else if (!armed) arm_cnt <= arm_cnt + 2'd1;
  end

  assign armed     = (arm_cnt == 2'd3);
  assign edge_det  = !armed ? '0 : (EDGE_TYPE ? (s2 & ~prev) : (~s2 & prev));
  assign grant_sel = (!fsm_rst && state == IDLE) ? lowest_set(pending) : '0;

  // A fresh edge on the channel being granted re-queues it rather than counting as overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      overflow <= '0;
    end else begin
      pending  <= (pending & ~grant_sel) | edge_det;
      overflow <= (clr_overflow ? '0 : overflow) | (edge_det & pending & ~grant_sel);
    end
  end

  always_ff @(posedge clk) begin
    if (fsm_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pulse_out <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant_sel) begin
            state     <= PULSE;
            cnt       <= pulse_len(grant_sel);
            pulse_out <= grant_sel;
            busy      <= 1'b1;
          end
        end
        PULSE: begin
          if (cnt == CNT_W'(1)) begin
            pulse_out <= '0;
            if (HOLDOFF == 0) begin
              state <= IDLE;
              cnt   <= '0;
              busy  <= 1'b0;
            end else begin
              state <= HOLD;
              cnt   <= CNT_W'(HOLDOFF);
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        HOLD: begin
          if (cnt == CNT_W'(1)) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          pulse_out <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hps_reset_pulse_sequencer.sv
// Directed bench for hps_reset_pulse_sequencer: default instance plus a falling-edge, zero-length, no-holdoff instance.
module tb_hps_reset_pulse_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req_a, req_b;
  logic       clr_a, clr_b;
  logic [2:0] pulse_a, pend_a, ovf_a;
  logic [2:0] pulse_b, pend_b, ovf_b;
  logic       busy_a, busy_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hps_reset_pulse_sequencer dut_a (
    .clk(clk), .rst(rst), .req_in(req_a), .clr_overflow(clr_a),
    .pulse_out(pulse_a), .pending(pend_a), .overflow(ovf_a), .busy(busy_a)
  );

  hps_reset_pulse_sequencer #(
    .PULSE_EXT_VEC({8'd32, 8'd2, 8'd0}),
    .EDGE_TYPE(1'b0),
    .HOLDOFF(0)
  ) dut_b (
    .clk(clk), .rst(rst), .req_in(req_b), .clr_overflow(clr_b),
    .pulse_out(pulse_b), .pending(pend_b), .overflow(ovf_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int seen, c0, c2, last_c0, first_c2, multi, rises, bz, pl;
  logic p2_prev;

  initial begin
    rst = 1'b1; req_a = 3'b001; req_b = 3'b111; clr_a = 1'b0; clr_b = 1'b0;
    tick(3);
    check("rst_pulse", pulse_a, 0);
    check("rst_pending", pend_a, 0);
    check("rst_overflow", ovf_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_pulse_b", pulse_b, 0);

    // Static high level at reset release must not look like an edge.
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      seen = seen | int'(pulse_a) | int'(pend_a);
    end
    check("arm_no_pulse", seen, 0);
    req_a = 3'b000;
    tick(5);
    check("arm_pending", pend_a, 0);

    // Single ch1 edge.
    req_a = 3'b010;
    tick(3);
    check("ch1_pending", pend_a, 3'b010);
    check("ch1_pre_pulse", pulse_a, 0);
    tick();
    check("ch1_pulse", pulse_a, 3'b010);
    check("ch1_pend_clr", pend_a, 0);
    check("ch1_busy", busy_a, 1);
    pl = 1; bz = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (pulse_a == 3'b010) pl++;
      if (busy_a) bz++;
    end
    check("ch1_len", pl, 2);
    check("ch1_busy_len", bz, 18);
    check("ch1_idle_busy", busy_a, 0);
    req_a = 3'b000;
    tick(5);

    // Simultaneous ch0 and ch2 edges.
    req_a = 3'b101;
    tick(4);
    check("dual_first", pulse_a, 3'b001);
    check("dual_pend", pend_a, 3'b100);
    c0 = 0; c2 = 0; last_c0 = -1; first_c2 = -1; multi = 0;
    for (int i = 0; i < 80; i++) begin
      if (pulse_a == 3'b001) begin c0++; last_c0 = i; end
      if (pulse_a == 3'b100) begin c2++; if (first_c2 < 0) first_c2 = i; end
      if (pulse_a != 3'b000 && pulse_a != 3'b001 && pulse_a != 3'b010 && pulse_a != 3'b100) multi++;
      tick();
    end
    check("dual_c0_len", c0, 6);
    check("dual_c2_len", c2, 32);
    check("dual_gap", first_c2 - last_c0 - 1, 17);
    check("dual_onehot", multi, 0);
    check("dual_end_busy", busy_a, 0);
    req_a = 3'b000;
    tick(5);

    // Two ch2 edges while ch1 is being served merge into one ch2 pulse.
    req_a = 3'b010;
    tick(4);
    check("ovf_ch1_grant", pulse_a, 3'b010);
    req_a = 3'b110; tick(2);
    req_a = 3'b010; tick(2);
    req_a = 3'b110; tick(2);
    req_a = 3'b010; tick(4);
    check("ovf_pending", pend_a, 3'b100);
    check("ovf_flag", ovf_a, 3'b100);
    rises = 0; c2 = 0; p2_prev = pulse_a[2];
    for (int i = 0; i < 80; i++) begin
      tick();
      if (pulse_a[2] && !p2_prev) rises++;
      if (pulse_a[2]) c2++;
      p2_prev = pulse_a[2];
    end
    check("ovf_single_pulse", rises, 1);
    check("ovf_c2_len", c2, 32);
    check("ovf_sticky", ovf_a, 3'b100);
    clr_a = 1'b1; tick();
    clr_a = 1'b0;
    check("ovf_cleared", ovf_a, 0);
    req_a = 3'b000;
    tick(5);

    // Reset during cycle 10 of a ch2 pulse.
    req_a = 3'b100;
    tick(4);
    check("rstp_grant", pulse_a, 3'b100);
    tick(9);
    rst = 1'b1; tick(); rst = 1'b0;
`ifdef HPS_RSTSEQ_IGNORE_RST_WHILE_BUSY_EN
    pl = 10;
    for (int i = 0; i < 40 && pulse_a == 3'b100; i++) begin
      pl++;
      tick();
    end
    check("rstp_full_len", pl, 32);
    tick();
    check("rstp_busy", busy_a, 0);
`else
    check("rstp_pulse", pulse_a, 0);
    check("rstp_busy", busy_a, 0);
`endif
    req_a = 3'b000;
    tick(5);
    check("rstp_pending", pend_a, 0);

    // Falling-edge instance, zero programmed length, no holdoff.
    req_b = 3'b110;
    tick(3);
    check("b_pending", pend_b, 3'b001);
    tick();
    check("b_pulse", pulse_b, 3'b001);
    check("b_busy", busy_b, 1);
    tick();
    check("b_pulse_len1", pulse_b, 0);
    check("b_idle", busy_b, 0);
    req_b = 3'b111;
    tick(6);
    check("b_rise_ignored", pend_b, 0);
    check("b_no_pulse", pulse_b, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
